// File: rtl/uart_word_bridge.sv
// Byte-stream to operand bridge: assembles IN_BYTES UART bytes into one operand, starts
// the compute unit, then serialises its result as OUT_BYTES bytes back to the transmitter.
module uart_word_bridge #(
    parameter int IN_BYTES       = 3,
    parameter int IN_WIDTH       = 18,
    parameter int OUT_BYTES      = 6,
    parameter int OUT_WIDTH      = 48,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TX_GUARD       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done_tick,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [IN_WIDTH-1:0]  op_data,
    output logic                 op_start,
    input  logic [OUT_WIDTH-1:0] res_data,
    input  logic                 res_valid,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overrun
);

    localparam int IN_BITS  = IN_BYTES * 8;
    localparam int OUT_BITS = OUT_BYTES * 8;
    localparam int RD_W     = $clog2(IN_BYTES + 1);
    localparam int WR_W     = $clog2(OUT_BYTES + 1);
    localparam int GD_W     = (TX_GUARD > 0) ? $clog2(TX_GUARD + 1) : 1;
    localparam int ID_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_READ     = 2'd0,
        S_START_OP = 2'd1,
        S_WAIT_RES = 2'd2,
        S_WRITE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [WR_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [GD_W-1:0]       guard_q, guard_d;
    logic [ID_W-1:0]       idle_q, idle_d;
    logic                  tx_wait_q, tx_wait_d;
    logic [IN_BITS-1:0]    asm_q, asm_d;
    logic [OUT_BITS-1:0]   res_q, res_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic [IN_WIDTH-1:0]   op_data_q, op_data_d;
    logic                  op_start_q, op_start_d;
    logic                  busy_q, busy_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  overrun_q, overrun_d;

    // Next-state and registered-output logic for the frame FSM
    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        guard_d       = guard_q;
        idle_d        = idle_q;
        tx_wait_d     = tx_wait_q;
        asm_d         = asm_q;
        res_d         = res_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        op_data_d     = op_data_q;
        op_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = overrun_q | (rx_done_tick & (state_q != S_READ));

        case (state_q)
            S_READ: begin
                if (rx_done_tick) begin
                    idle_d = '0;
                    if (MSB_FIRST) begin
                        asm_d      = asm_q << 8;
                        asm_d[7:0] = rx_data;
                    end else begin
                        for (int i = 0; i < IN_BYTES; i++) begin
                            asm_d[8*i +: 8] = (rd_cnt_q == RD_W'(i)) ? rx_data : asm_q[8*i +: 8];
                        end
                    end
                    if (rd_cnt_q == RD_W'(IN_BYTES - 1)) begin
                        rd_cnt_d   = '0;
                        op_data_d  = asm_d[IN_WIDTH-1:0];
                        op_start_d = 1'b1;
                        state_d    = S_START_OP;
                    end else begin
                        rd_cnt_d = rd_cnt_q + RD_W'(1);
                    end
                end else if ((TIMEOUT_CYCLES > 0) && (rd_cnt_q != '0)) begin
                    // A tick in the expiry cycle is handled above, so it always wins
                    if (idle_q == ID_W'(TIMEOUT_CYCLES - 1)) begin
                        rd_cnt_d      = '0;
                        idle_d        = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        idle_d = idle_q + ID_W'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            S_START_OP: begin
                state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    res_d                  = '0;
                    res_d[OUT_WIDTH-1:0]   = res_data;
                    wr_cnt_d               = '0;
                    guard_d                = '0;
                    tx_wait_d              = 1'b0;
                    state_d                = S_WRITE;
                end else begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WRITE: begin
                if (!tx_wait_q) begin
                    if (!tx_busy) begin
                        for (int k = 0; k < OUT_BYTES; k++) begin
                            tx_data_d = (wr_cnt_q == WR_W'(k))
                                      ? res_q[8*(MSB_FIRST ? (OUT_BYTES - 1 - k) : k) +: 8]
                                      : tx_data_d;
                        end
                        tx_start_d = 1'b1;
                        tx_wait_d  = 1'b1;
                        guard_d    = '0;
                    end else begin
                        tx_wait_d = 1'b0;
                    end
                end else if (guard_q != GD_W'(TX_GUARD)) begin
                    guard_d = guard_q + GD_W'(1);
                end else if (!tx_busy) begin
                    tx_wait_d = 1'b0;
                    if (wr_cnt_q == WR_W'(OUT_BYTES - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = S_READ;
                    end else begin
                        wr_cnt_d = wr_cnt_q + WR_W'(1);
                    end
                end else begin
                    tx_wait_d = 1'b1;
                end
            end
            default: begin
                state_d = S_READ;
            end
        endcase

        busy_d = (state_d != S_READ);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_READ;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            guard_q       <= '0;
            idle_q        <= '0;
            tx_wait_q     <= 1'b0;
            asm_q         <= '0;
            res_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            op_data_q     <= '0;
            op_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            guard_q       <= guard_d;
            idle_q        <= idle_d;
            tx_wait_q     <= tx_wait_d;
            asm_q         <= asm_d;
            res_q         <= res_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            op_data_q     <= op_data_d;
            op_start_q    <= op_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign op_data     = op_data_q;
    assign op_start    = op_start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule
